// File: rtl/iccm_loader_pkg.sv
// Shared types and constants for the ICCM boot loader.
package iccm_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [31:0] END_WORD       = 32'h0000_0FFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/iccm_loader_if.sv
// ICCM controller write port plus the SRAM ownership select driven by the loader.
interface iccm_loader_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0] iccm_ctrl_addr;
  logic [DATA_W-1:0] iccm_ctrl_wdata;
  logic              iccm_ctrl_we;
  logic              iccm_wsel;

  modport master (
    output iccm_ctrl_addr,
    output iccm_ctrl_wdata,
    output iccm_ctrl_we,
    output iccm_wsel
  );

  modport slave (
    input iccm_ctrl_addr,
    input iccm_ctrl_wdata,
    input iccm_ctrl_we,
    input iccm_wsel
  );

endinterface

// File: rtl/iccm_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; the first byte lands in bits [7:0].
module iccm_word_assembler
  import iccm_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  input  logic        valid_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      low_q, low_d;
  logic             take_s;

  assign take_s = en_i & valid_i;

  // The last byte bypasses storage so the word can be judged on its own strobe cycle.
  assign word_o       = {byte_i, low_q};
  assign word_valid_o = take_s && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  // Next byte count and lower-byte storage.
  always_comb begin
    cnt_d = cnt_q;
    low_d = low_q;
    if (clear_i) begin
      cnt_d = '0;
      low_d = 24'd0;
    end else if (take_s) begin
      cnt_d = cnt_q + CNT_W'(1);
      case (cnt_q)
        2'd0:    low_d[7:0]   = byte_i;
        2'd1:    low_d[15:8]  = byte_i;
        2'd2:    low_d[23:16] = byte_i;
        default: low_d        = low_q;
      endcase
    end else begin
      cnt_d = cnt_q;
      low_d = low_q;
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      low_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      low_q <= low_d;
    end
  end

endmodule

// File: rtl/iccm_loader.sv
// Boot-time ICCM loader: streams UART bytes into ICCM words and holds the core in reset meanwhile.
// Optional idle timeout in LOAD is enabled with the ICCM_LOADER_TIMEOUT_EN macro.
module iccm_loader #(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DATA_W   = 32,
  parameter logic [31:0] END_WORD = iccm_loader_pkg::END_WORD,
  parameter int unsigned MAX_ADDR = 2**ADDR_W - 1
`ifdef ICCM_LOADER_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [7:0]           rx_byte_i,
  input  logic                 rx_valid_i,
  iccm_loader_if.master        iccm_if,
  output logic                 core_rst_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  import iccm_loader_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              wsel_q, wsel_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept_start_s;
  logic              asm_en_s;
  logic [31:0]       word_s;
  logic              word_valid_s;
  logic              timeout_s;

  assign accept_start_s = (state_q == IDLE) && start_i;
  assign asm_en_s       = (state_q == LOAD) || (state_q == WRITE);

  iccm_word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (accept_start_s),
    .en_i         (asm_en_s),
    .byte_i       (rx_byte_i),
    .valid_i      (rx_valid_i),
    .word_o       (word_s),
    .word_valid_o (word_valid_s)
  );

`ifdef ICCM_LOADER_TIMEOUT_EN
  logic [23:0] idle_q, idle_d;

  // Idle counter runs only while a load is active and restarts on every byte.
  always_comb begin
    if (rx_valid_i || !asm_en_s) begin
      idle_d = 24'd0;
    end else begin
      idle_d = idle_q + 24'd1;
    end
  end

  assign timeout_s = (state_q == LOAD) && !rx_valid_i && ((idle_q + 24'd1) >= TIMEOUT_CYCLES);

  // Idle counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_q <= 24'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // FSM state and load bookkeeping registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Next state, write address and sticky error.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          addr_d  = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (word_valid_s) begin
          if (word_s == END_WORD) begin
            state_d = DONE;
          end else if (ovf_q) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WRITE;
          end
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      WRITE: begin
        state_d = LOAD;
        // Past the last word the address parks and the flag turns the next word into an error.
        if (addr_q == LAST_ADDR) begin
          ovf_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the coming state, so every output is registered.
  always_comb begin
    we_d       = (state_d == WRITE);
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (we_d) begin
      waddr_d = addr_q;
      wdata_d = DATA_W'(word_s);
    end else begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end
    busy_d     = (state_d == LOAD) || (state_d == WRITE);
    wsel_d     = !busy_d;
    core_rst_d = busy_d;
    done_d     = (state_d == DONE);
  end

  // Output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      waddr_q    <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      wsel_q     <= 1'b1;
      core_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      wsel_q     <= wsel_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign iccm_if.iccm_ctrl_addr  = waddr_q;
  assign iccm_if.iccm_ctrl_wdata = wdata_q;
  assign iccm_if.iccm_ctrl_we    = we_q;
  assign iccm_if.iccm_wsel       = wsel_q;
  assign core_rst_o              = core_rst_q;
  assign busy_o                  = busy_q;
  assign done_o                  = done_q;
  assign err_o                   = err_q;

endmodule

// File: tb/tb_iccm_loader.sv
// Self-checking bench for iccm_loader: random byte streams against a word-level reference model.
module tb_iccm_loader;

  localparam int          ADDR_W    = 13;
  localparam int          DATA_W    = 32;
  localparam int          MAX_WORDS = 8192;
  localparam logic [31:0] END_W     = 32'h0000_0FFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       core_rst, busy, done, err;

  iccm_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iccm_loader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef ICCM_LOADER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(24'd100)
`endif
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .rx_byte_i  (rx_byte),
    .rx_valid_i (rx_valid),
    .iccm_if    (bus),
    .core_rst_o (core_rst),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] obs_addr_q[$];
  logic [31:0]       obs_data_q[$];
  int                obs_cyc_q[$];
  int                done_cnt   = 0;
  int                done_cyc   = 0;
  logic              done_err   = 1'b0;
  int                illegal_we = 0;

  logic [7:0]        byte_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];
  int                exp_cyc_q[$];
  bit                exp_done, exp_err;

  always @(negedge clk) begin
    if (bus.iccm_ctrl_we === 1'b1) begin
      obs_addr_q.push_back(bus.iccm_ctrl_addr);
      obs_data_q.push_back(bus.iccm_ctrl_wdata);
      obs_cyc_q.push_back(cyc);
      if (bus.iccm_wsel !== 1'b0) illegal_we <= illegal_we + 1;
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      done_err <= err;
    end
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom; while (w == END_W);
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    obs_addr_q.delete();
    obs_data_q.delete();
    obs_cyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int c);
    c        = cyc;
    rx_byte  = b;
    rx_valid = 1'b1;
    idle(1);
    rx_valid = 1'b0;
    rx_byte  = $urandom_range(255, 0);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) byte_q.push_back(w[8*k +: 8]);
  endtask

  // Drives byte_q with random gaps and builds the expected write list from the byte stream.
  task automatic run_stream(input int max_gap, input int start_idx);
    int          c;
    int          n;
    int          strobe_q[$];
    logic [31:0] w;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_cyc_q.delete();
    for (int i = 0; i < byte_q.size(); i++) begin
      if (i == start_idx) pulse_start();
      idle($urandom_range(max_gap, 0));
      send_byte(byte_q[i], c);
      strobe_q.push_back(c);
    end
    n        = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    for (int wi = 0; wi < byte_q.size() / 4; wi++) begin
      w = {byte_q[4*wi+3], byte_q[4*wi+2], byte_q[4*wi+1], byte_q[4*wi]};
      if (w == END_W) begin
        exp_done = 1'b1;
        break;
      end
      if (n == MAX_WORDS) begin
        exp_done = 1'b1;
        exp_err  = 1'b1;
        break;
      end
      exp_addr_q.push_back(ADDR_W'(n));
      exp_data_q.push_back(w);
      exp_cyc_q.push_back(strobe_q[4*wi+3] + 1);
      n++;
    end
    idle(4);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    idle(3);
    checks++;
    if ({bus.iccm_ctrl_addr, bus.iccm_ctrl_wdata, bus.iccm_ctrl_we} !== {13'd0, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_bus: got addr=%0d data=%h we=%b, want 0 0 0",
               bus.iccm_ctrl_addr, bus.iccm_ctrl_wdata, bus.iccm_ctrl_we);
    end
    checks++;
    if ({bus.iccm_wsel, core_rst} !== 2'b10) begin
      failures++;
      $display("FAIL reset_own: got wsel=%b core_rst=%b, want 1 0", bus.iccm_wsel, core_rst);
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_status: got busy=%b done=%b err=%b, want 0 0 0", busy, done, err);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    clear_obs();
    byte_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
               8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00};
    pulse_start();
    run_stream(2, -1);
    checks++;
    if (obs_addr_q.size() !== 3 || exp_addr_q.size() !== 3) begin
      failures++;
      $display("FAIL basic_count: got %0d writes, want 3 (model %0d)", obs_addr_q.size(), exp_addr_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      checks++;
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_data_q[i] || obs_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++;
        $display("FAIL basic_write[%0d]: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d", i,
                 obs_addr_q[i], obs_data_q[i], obs_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: got done_cycles=%0d err_at_done=%b, want 1 0", done_cnt, done_err);
    end
    checks++;
    if ({bus.iccm_wsel, core_rst, busy, err} !== 4'b1000) begin
      failures++;
      $display("FAIL basic_after: got wsel=%b core_rst=%b busy=%b err=%b, want 1 0 0 0",
               bus.iccm_wsel, core_rst, busy, err);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    byte_q.delete();
    push_word(rand_word());
    push_word(rand_word());
    push_word(END_W);
    pulse_start();
    run_stream(0, -1);
    checks++;
    if (obs_addr_q.size() !== exp_addr_q.size()) begin
      failures++;
      $display("FAIL b2b_count: got %0d writes, want %0d", obs_addr_q.size(), exp_addr_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      checks++;
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_data_q[i] || obs_cyc_q[i] !== exp_cyc_q[i]) begin
        failures++;
        $display("FAIL b2b_write[%0d]: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d", i,
                 obs_addr_q[i], obs_data_q[i], obs_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL b2b_done: got done_cycles=%0d, want 1", done_cnt);
    end
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      clear_obs();
      byte_q.delete();
      repeat ($urandom_range(6, 1)) push_word(rand_word());
      push_word(END_W);
      pulse_start();
      run_stream(3, -1);
      checks++;
      if (obs_addr_q.size() !== exp_addr_q.size() || done_cnt !== 1 || err !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_summary: got writes=%0d done=%0d err=%b, want writes=%0d done=1 err=0",
                 it, obs_addr_q.size(), done_cnt, err, exp_addr_q.size());
      end
      for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
        checks++;
        if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_data_q[i] || obs_cyc_q[i] !== exp_cyc_q[i]) begin
          failures++;
          $display("FAIL rand%0d_write[%0d]: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d", it, i,
                   obs_addr_q[i], obs_data_q[i], obs_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    clear_obs();
    byte_q.delete();
    push_word(rand_word());
    push_word(rand_word());
    push_word(END_W);
    pulse_start();
    run_stream(1, 2);
    checks++;
    if (obs_addr_q.size() !== exp_addr_q.size() || done_cnt !== 1) begin
      failures++;
      $display("FAIL start_ign_summary: got writes=%0d done=%0d, want writes=%0d done=1",
               obs_addr_q.size(), done_cnt, exp_addr_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      checks++;
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_data_q[i]) begin
        failures++;
        $display("FAIL start_ign_write[%0d]: got addr=%0d data=%h, want addr=%0d data=%h", i,
                 obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int          c;
    logic [31:0] w0;
    clear_obs();
    w0 = rand_word();
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], c);
    send_byte($urandom_range(255, 0), c);
    send_byte($urandom_range(255, 0), c);
    checks++;
    if ({bus.iccm_wsel, core_rst, busy} !== 3'b011) begin
      failures++;
      $display("FAIL midload_own: got wsel=%b core_rst=%b busy=%b, want 0 1 1", bus.iccm_wsel, core_rst, busy);
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({bus.iccm_wsel, core_rst, bus.iccm_ctrl_we} !== 3'b100) begin
      failures++;
      $display("FAIL rst_abort: got wsel=%b core_rst=%b we=%b, want 1 0 0",
               bus.iccm_wsel, core_rst, bus.iccm_ctrl_we);
    end
    idle(2);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) send_byte($urandom_range(255, 0), c);
    idle(3);
    checks++;
    if (obs_addr_q.size() !== 1 || obs_data_q[0] !== w0 || done_cnt !== 0) begin
      failures++;
      $display("FAIL rst_no_write: got writes=%0d first=%h done=%0d, want writes=1 first=%h done=0",
               obs_addr_q.size(), (obs_data_q.size() > 0) ? obs_data_q[0] : 32'h0, done_cnt, w0);
    end
  endtask

  task automatic test_overflow();
    int bad;
    clear_obs();
    byte_q.delete();
    repeat (MAX_WORDS + 1) push_word(rand_word());
    pulse_start();
    run_stream(0, -1);
    checks++;
    if (obs_addr_q.size() !== MAX_WORDS || exp_addr_q.size() !== MAX_WORDS) begin
      failures++;
      $display("FAIL ovf_count: got %0d writes, want %0d (model %0d)", obs_addr_q.size(), MAX_WORDS, exp_addr_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_data_q[i] || obs_cyc_q[i] !== exp_cyc_q[i]) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL ovf_writes: got %0d mismatching writes, want 0", bad);
    end
    checks++;
    if (done_cnt !== 1 || done_err !== 1'b1 || err !== 1'b1 || exp_err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_err: got done_cycles=%0d err_at_done=%b err=%b, want 1 1 1", done_cnt, done_err, err);
    end
  endtask

  task automatic test_err_clear();
    clear_obs();
    pulse_start();
    checks++;
    if ({err, bus.iccm_wsel} !== 2'b00) begin
      failures++;
      $display("FAIL err_clear: got err=%b wsel=%b after start, want 0 0", err, bus.iccm_wsel);
    end
    byte_q.delete();
    push_word(END_W);
    run_stream(0, -1);
    checks++;
    if (done_cnt !== 1 || obs_addr_q.size() !== 0) begin
      failures++;
      $display("FAIL err_clear_end: got done=%0d writes=%0d, want 1 0", done_cnt, obs_addr_q.size());
    end
  endtask

`ifdef ICCM_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    int c;
    clear_obs();
    pulse_start();
    send_byte($urandom_range(255, 0), c);
    send_byte($urandom_range(255, 0), c);
    idle(110);
    checks++;
    if (done_cnt !== 1 || done_err !== 1'b1 || obs_addr_q.size() !== 0 || done_cyc !== c + 101) begin
      failures++;
      $display("FAIL timeout: got done=%0d err=%b writes=%0d done_cyc=%0d, want 1 1 0 %0d",
               done_cnt, done_err, obs_addr_q.size(), done_cyc, c + 101);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random(3);
    test_start_ignored();
    test_reset_mid_load();
    test_overflow();
    test_err_clear();
`ifdef ICCM_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (illegal_we !== 0) begin
      failures++;
      $display("FAIL we_ownership: got %0d writes while wsel=1, want 0", illegal_we);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
